// File: rtl/ibpl_pkg.sv
// ============================================================================
// Module   : ibpl_pkg
// Brief    : Shared types and helpers for the interbackplane GPIO cardlet.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ibpl_pkg;

    localparam int IBPL_MAX_CH = 8;

    typedef enum logic [2:0] {
        CH_OFF   = 3'd0,
        CH_IN    = 3'd1,
        CH_TURN  = 3'd2,
        CH_OUT   = 3'd3,
        CH_FAULT = 3'd4
    } ch_state_t;

    // Width of a down/up counter that must hold max_val; never narrower than 1.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibpl_debounce.sv
// ============================================================================
// Module   : ibpl_debounce
// Brief    : One channel's 2-FF synchroniser, debouncer and change strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibpl_debounce
    import ibpl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic nReset,
    input  logic i_pin,
    output logic o_deb,
    output logic o_deb_chg
);

    localparam int                 c_cnt_w   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_deb;
    logic [c_cnt_w-1:0] r_cnt;

    // Strobe is high on the cycle the debounced value is about to flip.
    assign o_deb_chg = (r_sync2 != r_deb) && (r_cnt == c_cnt_max);
    assign o_deb     = r_deb;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (o_deb_chg) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ibpl_gpio_cardlet.sv
// ============================================================================
// Module   : ibpl_gpio_cardlet
// Brief    : Parametrised GPIO cardlet: per-channel direction FSMs, debounced
//            inputs, turnaround-protected outputs, stretched LEDs, fault flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibpl_gpio_cardlet
    import ibpl_pkg::*;
#(
    parameter int N_CH               = 6,
    parameter int EN_W               = 16,
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int TURN_CYCLES        = 4,
    parameter int LED_STRETCH_CYCLES = 2_000_000
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic [EN_W-1:0]        output_enable,
    input  logic [EN_W-1:0]        input_enable,
    input  logic [N_CH-1:0]        diob_in,
    input  logic [N_CH-1:0]        internal_out,
    input  logic                   err_clr,
    output logic [N_CH-1:0]        diob_dir,
    output logic [N_CH-1:0]        diob_out,
    output logic [IBPL_MAX_CH-1:0] internal_in,
    output logic [IBPL_MAX_CH-1:0] diob_led1,
    output logic [IBPL_MAX_CH-1:0] diob_led2,
    output logic                   plugin_error,
    output logic                   err_sticky
);

    localparam int                  c_turn_load_i = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;
    localparam int                  c_turn_w      = cnt_width(c_turn_load_i);
    localparam logic [c_turn_w-1:0] c_turn_load   = c_turn_w'(c_turn_load_i);
    localparam int                  c_led_w       = cnt_width(LED_STRETCH_CYCLES);
    localparam logic [c_led_w-1:0]  c_led_load    = c_led_w'(LED_STRETCH_CYCLES);

    logic [EN_W-1:0]     r_oe_q;
    logic [EN_W-1:0]     r_ie_q;
    logic                r_err;
    logic                r_sticky;
    logic                w_oor;
    logic                w_conflict;
    logic [N_CH-1:0]     r_out_q;
    logic [N_CH-1:0]     r_dout_prev;
    logic [N_CH-1:0]     w_dir;
    logic [N_CH-1:0]     w_dout;
    logic [N_CH-1:0]     w_deb;
    logic [N_CH-1:0]     w_deb_chg;
    logic [N_CH-1:0]     w_in;
    logic [N_CH-1:0]     w_led1;
    logic [N_CH-1:0]     w_led2;
    ch_state_t           r_state     [N_CH];
    ch_state_t           w_state_nxt [N_CH];
    logic [c_turn_w-1:0] r_turn_cnt  [N_CH];
    logic [c_turn_w-1:0] w_turn_nxt  [N_CH];

    assign w_oor      = |((r_oe_q | r_ie_q) >> N_CH);
    assign w_conflict = |(r_oe_q[N_CH-1:0] & r_ie_q[N_CH-1:0]);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_oe_q      <= '0;
            r_ie_q      <= '0;
            r_err       <= 1'b0;
            r_sticky    <= 1'b0;
            r_out_q     <= '0;
            r_dout_prev <= '0;
        end else begin
            r_oe_q      <= output_enable;
            r_ie_q      <= input_enable;
            r_err       <= w_oor | w_conflict;
            // Set has priority over a coincident clear.
            r_sticky    <= r_err | (r_sticky & ~err_clr);
            r_out_q     <= internal_out;
            r_dout_prev <= w_dout;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i]    <= CH_OFF;
                r_turn_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i]    <= w_state_nxt[i];
                r_turn_cnt[i] <= w_turn_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_state_nxt[i] = CH_OFF;
            w_turn_nxt[i]  = r_turn_cnt[i];
            case ({r_oe_q[i], r_ie_q[i]})
                2'b11: w_state_nxt[i] = CH_FAULT;
                2'b01: w_state_nxt[i] = CH_IN;
                2'b10: begin
                    if (r_state[i] == CH_OUT) begin
                        w_state_nxt[i] = CH_OUT;
                    end else if (r_state[i] == CH_TURN) begin
                        if (r_turn_cnt[i] == '0) begin
                            w_state_nxt[i] = CH_OUT;
                        end else begin
                            w_state_nxt[i] = CH_TURN;
                            w_turn_nxt[i]  = r_turn_cnt[i] - 1'b1;
                        end
                    end else begin
                        w_state_nxt[i] = CH_TURN;
                        w_turn_nxt[i]  = c_turn_load;
                    end
                end
                default: w_state_nxt[i] = CH_OFF;
            endcase
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [c_led_w-1:0] r_led1_cnt;
        logic [c_led_w-1:0] r_led2_cnt;

        ibpl_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .nReset   (nReset),
            .i_pin    (diob_in[g]),
            .o_deb    (w_deb[g]),
            .o_deb_chg(w_deb_chg[g])
        );

        assign w_dir[g]  = (r_state[g] == CH_OUT);
        assign w_dout[g] = w_dir[g] & r_out_q[g];
        assign w_in[g]   = (r_state[g] == CH_IN) & w_deb[g];
        assign w_led1[g] = (r_led1_cnt != '0);
        assign w_led2[g] = (r_led2_cnt != '0);

        always_ff @(posedge clk or negedge nReset) begin
            if (!nReset) begin
                r_led1_cnt <= '0;
                r_led2_cnt <= '0;
            end else begin
                if (w_deb_chg[g] && (r_state[g] == CH_IN)) begin
                    r_led1_cnt <= c_led_load;
                end else if (r_led1_cnt != '0) begin
                    r_led1_cnt <= r_led1_cnt - 1'b1;
                end
                if (w_dir[g] && (w_dout[g] != r_dout_prev[g])) begin
                    r_led2_cnt <= c_led_load;
                end else if (r_led2_cnt != '0) begin
                    r_led2_cnt <= r_led2_cnt - 1'b1;
                end
            end
        end
    end

    assign diob_dir     = w_dir;
    assign diob_out     = w_dout;
    assign internal_in  = IBPL_MAX_CH'(w_in);
    assign diob_led1    = IBPL_MAX_CH'(w_led1);
    assign diob_led2    = IBPL_MAX_CH'(w_led2);
    assign plugin_error = r_err;
    assign err_sticky   = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_ibpl_gpio_cardlet.sv
// ============================================================================
// Module   : tb_ibpl_gpio_cardlet
// Brief    : Self-checking bench for ibpl_gpio_cardlet with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibpl_gpio_cardlet;

    localparam int c_n_ch  = 6;
    localparam int c_en_w  = 16;
    localparam int c_deb   = 16;
    localparam int c_turn  = 4;
    localparam int c_led   = 40;
    localparam int c_turn_eff = (c_turn < 1) ? 1 : c_turn;

    logic                clk = 1'b0;
    logic                nReset = 1'b0;
    logic [c_en_w-1:0]   output_enable = '0;
    logic [c_en_w-1:0]   input_enable = '0;
    logic [c_n_ch-1:0]   diob_in = '0;
    logic [c_n_ch-1:0]   internal_out = '0;
    logic                err_clr = 1'b0;
    logic [c_n_ch-1:0]   diob_dir;
    logic [c_n_ch-1:0]   diob_out;
    logic [7:0]          internal_in;
    logic [7:0]          diob_led1;
    logic [7:0]          diob_led2;
    logic                plugin_error;
    logic                err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    ibpl_gpio_cardlet #(
        .N_CH              (c_n_ch),
        .EN_W              (c_en_w),
        .DEBOUNCE_CYCLES   (c_deb),
        .TURN_CYCLES       (c_turn),
        .LED_STRETCH_CYCLES(c_led)
    ) dut (
        .clk          (clk),
        .nReset       (nReset),
        .output_enable(output_enable),
        .input_enable (input_enable),
        .diob_in      (diob_in),
        .internal_out (internal_out),
        .err_clr      (err_clr),
        .diob_dir     (diob_dir),
        .diob_out     (diob_out),
        .internal_in  (internal_in),
        .diob_led1    (diob_led1),
        .diob_led2    (diob_led2),
        .plugin_error (plugin_error),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Channel mode follows the registered enables one cycle later; an output
    // channel drives once the output-only request has been seen for longer
    // than the turnaround window. An input is accepted once the last DEB+1
    // synchronised samples all disagree with the current debounced value.
    logic [c_en_w-1:0] m_oe_q, m_ie_q;
    int                m_streak  [c_n_ch];
    bit [c_n_ch-1:0]   m_inmode, m_dir, m_outq, m_p1, m_p2, m_deb, m_dout_cur, m_dout_last;
    bit [63:0]         m_hist    [c_n_ch];
    int                m_led1_t  [c_n_ch];
    int                m_led2_t  [c_n_ch];
    int                m_cyc;
    bit                m_err, m_sticky;

    task automatic model_reset();
        m_oe_q = '0; m_ie_q = '0; m_inmode = '0; m_dir = '0; m_outq = '0;
        m_p1 = '0; m_p2 = '0; m_deb = '0; m_dout_cur = '0; m_dout_last = '0;
        m_err = 1'b0; m_sticky = 1'b0; m_cyc = 0;
        for (int i = 0; i < c_n_ch; i++) begin
            m_streak[i] = 0; m_hist[i] = '0;
            m_led1_t[i] = -100000; m_led2_t[i] = -100000;
        end
    endtask

    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            model_reset();
        end else begin
            bit [63:0] mask;
            bit        was_in;
            bit        sv;
            mask = (64'd1 << (c_deb + 1)) - 64'd1;
            m_cyc = m_cyc + 1;
            for (int i = 0; i < c_n_ch; i++)
                if (m_dir[i] && (m_dout_cur[i] != m_dout_last[i])) m_led2_t[i] = m_cyc;
            m_dout_last = m_dout_cur;
            m_sticky = m_err || (m_sticky && !err_clr);
            m_err = ((m_oe_q | m_ie_q) >> c_n_ch) != 0 ||
                    (m_oe_q[c_n_ch-1:0] & m_ie_q[c_n_ch-1:0]) != 0;
            for (int i = 0; i < c_n_ch; i++) begin
                was_in = m_inmode[i];
                m_streak[i] = (m_oe_q[i] && !m_ie_q[i]) ? m_streak[i] + 1 : 0;
                m_inmode[i] = m_ie_q[i] && !m_oe_q[i];
                m_dir[i]    = m_streak[i] >= c_turn_eff + 1;
                sv = m_p2[i];
                m_hist[i] = {m_hist[i][62:0], sv};
                if ((m_hist[i] & mask) == (m_deb[i] ? 64'd0 : mask)) begin
                    m_deb[i] = sv;
                    if (was_in) m_led1_t[i] = m_cyc;
                end
            end
            m_outq = internal_out;
            m_p2 = m_p1;
            m_p1 = diob_in;
            m_oe_q = output_enable;
            m_ie_q = input_enable;
            m_dout_cur = m_dir & m_outq;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        logic [7:0] e_in, e_l1, e_l2;
        e_in = '0; e_l1 = '0; e_l2 = '0;
        for (int i = 0; i < c_n_ch; i++) begin
            e_in[i] = m_inmode[i] & m_deb[i];
            e_l1[i] = (m_cyc - m_led1_t[i]) < c_led;
            e_l2[i] = (m_cyc - m_led2_t[i]) < c_led;
        end
        chk("model_diob_dir", 32'(diob_dir), 32'(m_dir));
        chk("model_diob_out", 32'(diob_out), 32'(m_dir & m_outq));
        chk("model_internal_in", 32'(internal_in), 32'(e_in));
        chk("model_led1", 32'(diob_led1), 32'(e_l1));
        chk("model_led2", 32'(diob_led2), 32'(e_l2));
        chk("model_plugin_error", 32'(plugin_error), 32'(m_err));
        chk("model_err_sticky", 32'(err_sticky), 32'(m_sticky));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {diob_dir, diob_out, internal_in, diob_led1, diob_led2, plugin_error, err_sticky}, 0);
    endtask

    initial begin
        // Reset / idle
        diob_in = 6'h3F;
        cyc(5);
        chk_all_zero("reset_outputs_zero");
        nReset = 1'b1;
        cyc(3);
        chk("idle_plugin_error", 32'(plugin_error), 0);
        chk("idle_internal_in", 32'(internal_in), 0);
        diob_in = '0;
        cyc(25);

        // Out-of-range fault, 2-cycle latency, then clear
        output_enable = 16'h0040;
        cyc(1);
        chk("oor_err_after_1", 32'(plugin_error), 0);
        cyc(1);
        chk("oor_err_after_2", 32'(plugin_error), 1);
        cyc(1);
        chk("oor_sticky", 32'(err_sticky), 1);
        output_enable = '0;
        cyc(3);
        chk("oor_err_cleared", 32'(plugin_error), 0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("oor_sticky_cleared", 32'(err_sticky), 0);

        // Conflict on channel 0, channel 4 still turns on
        output_enable = 16'h0011;
        input_enable  = 16'h0001;
        cyc(7);
        chk("conflict_err", 32'(plugin_error), 1);
        chk("conflict_dir", 32'(diob_dir), 32'h10);
        output_enable = '0; input_enable = '0;
        cyc(4);

        // Turnaround on channel 2
        internal_out = 6'h3F;
        output_enable = 16'h0004;
        cyc(5);
        chk("turn_dir_before", 32'(diob_dir[2]), 0);
        cyc(1);
        chk("turn_dir_at_6", 32'(diob_dir[2]), 1);
        chk("turn_out", 32'(diob_out[2]), 1);
        cyc(1);
        chk("turn_led2", 32'(diob_led2[2]), 1);
        output_enable = '0;
        cyc(1);
        chk("release_dir_after_1", 32'(diob_dir[2]), 1);
        cyc(1);
        chk("release_dir_after_2", 32'(diob_dir[2]), 0);
        cyc(c_led + 2);

        // Debounce on channel 1
        input_enable = 16'h0002;
        cyc(3);
        diob_in[1] = 1'b1;
        cyc(10);
        diob_in[1] = 1'b0;
        cyc(30);
        chk("glitch_ignored", 32'(internal_in[1]), 0);
        chk("glitch_no_led", 32'(diob_led1[1]), 0);
        diob_in[1] = 1'b1;
        cyc(18);
        chk("deb_before_19", 32'(internal_in[1]), 0);
        cyc(1);
        chk("deb_at_19", 32'(internal_in[1]), 1);
        chk("deb_led1_on", 32'(diob_led1[1]), 1);
        cyc(c_led - 1);
        chk("led1_last_cycle", 32'(diob_led1[1]), 1);
        cyc(1);
        chk("led1_expired", 32'(diob_led1[1]), 0);
        input_enable = '0;
        diob_in = '0;
        cyc(25);

        // Simultaneous set and clear of sticky
        output_enable = 16'h0003;
        input_enable  = 16'h0001;
        cyc(4);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("set_wins_sticky", 32'(err_sticky), 1);
        output_enable = '0; input_enable = '0;
        cyc(4);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;

        // Asynchronous reset mid-operation
        output_enable = 16'h0008;
        input_enable  = 16'h0020;
        diob_in = 6'h20;
        cyc(25);
        chk("pre_reset_dir", 32'(diob_dir), 32'h08);
        #2 nReset = 1'b0;
        #1 chk_all_zero("async_reset_zero");
        cyc(2);
        nReset = 1'b1;
        output_enable = '0; input_enable = '0; diob_in = '0;
        cyc(25);

        // Randomised traffic
        for (int blk = 0; blk < 60; blk++) begin
            logic [c_en_w-1:0] oe, ie;
            int dur, rate;
            oe = '0; ie = '0;
            for (int c = 0; c < c_n_ch; c++) begin
                int r;
                r = int'($urandom_range(0, 19));
                if (r < 6) oe[c] = 1'b1;
                else if (r < 12) ie[c] = 1'b1;
                else if (r == 12) begin oe[c] = 1'b1; ie[c] = 1'b1; end
            end
            if ($urandom_range(0, 9) == 0) oe[c_n_ch + int'($urandom_range(0, c_en_w - c_n_ch - 1))] = 1'b1;
            output_enable = oe;
            input_enable = ie;
            dur = int'($urandom_range(5, 60));
            rate = ($urandom_range(0, 1) == 0) ? 4 : 40;
            for (int k = 0; k < dur; k++) begin
                for (int c = 0; c < c_n_ch; c++)
                    if ($urandom_range(0, rate - 1) == 0) diob_in[c] = ~diob_in[c];
                if ($urandom_range(0, 3) == 0) internal_out = c_n_ch'($urandom);
                err_clr = ($urandom_range(0, 15) == 0);
                cyc(1);
            end
        end
        err_clr = 1'b0;
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ibpl_gpio_cardlet.md
# ibpl_gpio_cardlet

Parametrised general-purpose I/O cardlet plugin for the SCU DIOB interbackplane: the successor to the fixed "empty/unknown" cardlet.
- Drives up to eight bidirectional backplane channels with per-channel direction control, input synchronisation and debouncing, output turnaround protection and stretched activity LEDs.
- Reports configuration faults on `plugin_error`, with a sticky copy held until cleared.
- One instance per cardlet slot, selected by the blackbox frontend.

## Interface
Parameters:
- `N_CH`, 6: implemented channels, 1..8.
- `EN_W`, 16: width of the enable vectors from the frontend config.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to accept an input change.
  - 0 bypasses the debounce stage.
- `TURN_CYCLES`, 4: high-Z cycles inserted before a channel drives.
- `LED_STRETCH_CYCLES`, 2_000_000: minimum LED on-time after activity.

Ports:
- `clk` in 1: system clock.
- `nReset` in 1: asynchronous, active-low reset.
- `output_enable` in EN_W: per-channel output request.
- `input_enable` in EN_W: per-channel input request.
- `diob_in` in N_CH: raw backplane pins; asynchronous.
- `internal_out` in N_CH: data to drive on output channels.
- `err_clr` in 1: single-cycle pulse that clears `err_sticky`.
- `diob_dir` out N_CH: 1 = channel drives.
- `diob_out` out N_CH: pin output data.
- `internal_in` out 8: debounced input data, zero-extended.
- `diob_led1` out 8: input activity LEDs, zero-extended.
- `diob_led2` out 8: output activity LEDs, zero-extended.
- `plugin_error` out 1: live fault indication.
- `err_sticky` out 1: latched fault.

## Operation
- Enables are registered once (`en_q`) before use.
- **Fault conditions**, evaluated on `en_q`:
  - (a) any bit at index ≥ N_CH set in either enable vector;
  - (b) any channel with both enables set.
- `plugin_error` is the registered OR of (a) and (b).
- `err_sticky` is set by `plugin_error` and cleared by `err_clr`. If both occur in the same cycle, set wins.
- **Per-channel FSM**, states OFF, IN, TURN, OUT, FAULT:
  - Next state is decided by that channel's `en_q` bits:
    - both set → FAULT;
    - output only → TURN, or stay in OUT if already there;
    - input only → IN;
    - none → OFF.
  - TURN loads a counter with TURN_CYCLES-1 and decrements it. At 0 it moves to OUT, if the output request still holds.
  - Dropping the output request while in TURN leaves TURN immediately.
  - OUT → IN and OUT → OFF are immediate; releasing the pin is always safe.
  - TURN_CYCLES = 0 means TURN lasts one cycle.
- **Outputs per state:**
  - `diob_dir` = 1 only in OUT.
  - `diob_out` = registered `internal_out` in OUT, else 0.
  - `internal_in` = debounced value in IN, else 0.
- **Input path**, running in every state:
  - 2-FF synchroniser, then debouncer.
  - The debouncer counter (width clog2(DEBOUNCE_CYCLES+1)) counts while the synchronised value differs from the debounced value.
  - It resets to 0 whenever the two are equal.
  - On reaching DEBOUNCE_CYCLES the debounced value takes the synchronised value and the counter returns to 0.
- **LEDs:**
  - `diob_led1[i]` is retriggered by any change of channel i's debounced value while in IN.
  - `diob_led2[i]` is retriggered by any change of `diob_out[i]` while in OUT.
  - Each LED holds for LED_STRETCH_CYCLES after its last trigger. The counter saturates at 0.
- Bits at index ≥ N_CH of every 8-bit output are tied to 0.

## Timing
- Reset values:
  - all FSMs OFF;
  - `diob_dir`, `diob_out`, `internal_in`, both LED vectors, `plugin_error`, `err_sticky` = 0;
  - synchronisers and debounced values = 0;
  - all counters = 0.
- Reset asserted mid-operation returns every output to its reset value asynchronously.
- Enable edge to `plugin_error`: 2 cycles (enable register, then error register).
- Output request edge to `diob_dir` = 1: 2 + TURN_CYCLES cycles.
- Request removal to `diob_dir` = 0: 2 cycles.
- Pin edge to `internal_in`, for a clean input: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- With DEBOUNCE_CYCLES = 0: 3 cycles.
- A glitch shorter than DEBOUNCE_CYCLES cycles after sync never reaches `internal_in`.
- `internal_out` to `diob_out`: 1 cycle in OUT.

## Structure
- Shared package `ibpl_pkg`:
  - channel state enum (OFF, IN, TURN, OUT, FAULT);
  - constant `IBPL_MAX_CH` = 8;
  - `clog2`-based counter-width helper.
- Sub-module `ibpl_debounce`: one channel's synchroniser, debouncer and LED-trigger output, instantiated N_CH times via generate.
- Channel FSMs, LED stretchers and error logic live in the top module.

## Test plan
- **Reset/idle**:
  - Stimulus: `nReset` low with `diob_in` = 6'h3F; release with enables 0.
  - Required: all outputs stay 0, `plugin_error` = 0.
- **Out-of-range fault**:
  - Stimulus: `output_enable` = 16'h0040 with N_CH = 6.
  - Required: `plugin_error` = 1 exactly 2 cycles later, `err_sticky` = 1.
  - Then clear the enable and pulse `err_clr`: both return to 0.
- **Conflict**:
  - Stimulus: both enables 16'h0001.
  - Required: channel 0 in FAULT, `diob_dir[0]` = 0, `plugin_error` = 1, other channels unaffected.
- **Turnaround**:
  - Stimulus: `output_enable` = 16'h0004, `internal_out` = 6'h3F.
  - Required: `diob_dir[2]` rises 2 + 4 cycles later, `diob_out[2]` = 1, `diob_led2[2]` = 1.
  - Then drop the request: `diob_dir[2]` = 0 two cycles later.
- **Debounce**:
  - Stimulus: channel 1 in IN, DEBOUNCE_CYCLES = 16; apply a 10-cycle high pulse, then a held high.
  - Required: the pulse is ignored; `internal_in[1]` rises 19 cycles after the held edge; `diob_led1[1]` = 1 for 2_000_000 cycles.
- **Simultaneous set/clear**:
  - Stimulus: `err_clr` in the same cycle as a live fault.
  - Required: `err_sticky` stays 1.
